// File: rtl/gf180mcu_fd_sc_mcu7t5v0__subs_serial_pkg.sv
// ----------------------------------------------------------------------------
// Package: gf180mcu_fd_sc_mcu7t5v0__subs_serial_pkg
// Purpose: shared definitions for the bit-serial subtractor family.
//   - controller state encoding (IDLE / RUN / DONE; 2'b11 is unused and
//     treated as IDLE by the controller)
//   - legal operand width bounds
// Ports:   none (package)
// ----------------------------------------------------------------------------
package gf180mcu_fd_sc_mcu7t5v0__subs_serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__subf_slice.sv
// ----------------------------------------------------------------------------
// Module: gf180mcu_fd_sc_mcu7t5v0__subf_slice
// Purpose: purely combinational one-bit full subtractor, a - b - bi.
// Ports:
//   a    in   minuend bit
//   b    in   subtrahend bit
//   bi   in   borrow-in
//   diff out  difference bit
//   bo   out  borrow-out
// ----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__subf_slice (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic diff,
   output logic bo
);

   assign diff = a ^ b ^ bi;
   // Borrow when b exceeds a outright, or when a==b and a borrow comes in.
   assign bo   = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__subs_serial.sv
// ----------------------------------------------------------------------------
// Module: gf180mcu_fd_sc_mcu7t5v0__subs_serial
// Purpose: bit-serial subtractor. Computes D = A - B - BI (unsigned, modulo
//   2^WIDTH) one bit per clock, LSB first, through a single full-subtractor
//   slice and a borrow flop. Operands enter and results leave over
//   valid/ready handshakes.
// Parameters:
//   WIDTH      operand/result width, 2..64
// Ports:
//   CLK        in   clock, rising edge
//   RN         in   asynchronous active-low reset
//   A, B, BI   in   minuend, subtrahend, borrow-in (sampled on input handshake)
//   IN_VALID   in   operands present
//   IN_READY   out  operands can be accepted (combinational from OUT_READY)
//   D          out  difference, stable while OUT_VALID
//   BO         out  borrow-out, 1 iff A < B + BI
//   OUT_VALID  out  D/BO valid
//   OUT_READY  in   consumer accepts result
//   BUSY       out  serial computation in progress
// ----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__subs_serial
   import gf180mcu_fd_sc_mcu7t5v0__subs_serial_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             BI,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [WIDTH-1:0] D,
   output logic             BO,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic             BUSY
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t            state;
   state_t            state_nxt;
   logic [WIDTH-1:0]  sa;
   logic [WIDTH-1:0]  sb;
   logic [WIDTH-1:0]  d_reg;
   logic              br;
   logic              bo_reg;
   logic [CNT_W-1:0]  cnt;
   logic              accept;
   logic              last;
   logic              slice_diff;
   logic              slice_bo;

   // DONE with OUT_READY counts as ready so a new operand set can be taken
   // in the same cycle the previous result is consumed.
   assign IN_READY  = (state == ST_IDLE) | ((state == ST_DONE) & OUT_READY);
   assign accept    = IN_VALID & IN_READY;
   assign last      = (cnt == CNT_LAST);
   assign OUT_VALID = (state == ST_DONE);
   assign BUSY      = (state == ST_RUN);
   assign D         = d_reg;
   assign BO        = bo_reg;

   gf180mcu_fd_sc_mcu7t5v0__subf_slice u_slice (
      .a    (sa[0]),
      .b    (sb[0]),
      .bi   (br),
      .diff (slice_diff),
      .bo   (slice_bo)
   );

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = ST_IDLE;
      case (state)
         ST_IDLE: state_nxt = accept ? ST_RUN : ST_IDLE;
         ST_RUN:  state_nxt = last ? ST_DONE : ST_RUN;
         ST_DONE: begin
            if (accept)         state_nxt = ST_RUN;
            else if (OUT_READY) state_nxt = ST_IDLE;
            else                state_nxt = ST_DONE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Operands are captured only on a handshake, so A/B/BI are never looked
   // at otherwise. D and BO change only while RUN and hold through DONE.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         sa     <= '0;
         sb     <= '0;
         d_reg  <= '0;
         br     <= 1'b0;
         bo_reg <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         sa  <= A;
         sb  <= B;
         br  <= BI;
         cnt <= '0;
      end else if (state == ST_RUN) begin
         sa    <= sa >> 1;
         sb    <= sb >> 1;
         d_reg <= {slice_diff, d_reg[WIDTH-1:1]};
         br    <= slice_bo;
         // Counter parks at the terminal value instead of wrapping.
         if (last) bo_reg <= slice_bo;
         else      cnt    <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__subs_serial.sv
module tb_gf180mcu_fd_sc_mcu7t5v0__subs_serial;

   logic       CLK = 1'b0;
   logic       RN  = 1'b0;
   always #5 CLK = ~CLK;

   // WIDTH=8 instance
   logic [7:0] A = '0, B = '0, D;
   logic       BI = 1'b0, IN_VALID = 1'b0, IN_READY, BO, OUT_VALID, OUT_READY = 1'b0, BUSY;
   // WIDTH=2 instance
   logic [1:0] A2 = '0, B2 = '0, D2;
   logic       BI2 = 1'b0, IN_VALID2 = 1'b0, IN_READY2, BO2, OUT_VALID2, OUT_READY2 = 1'b0, BUSY2;

   int n_tests = 0;
   int n_fail  = 0;

   gf180mcu_fd_sc_mcu7t5v0__subs_serial #(.WIDTH(8)) dut8 (
      .CLK(CLK), .RN(RN), .A(A), .B(B), .BI(BI), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .D(D), .BO(BO), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .BUSY(BUSY)
   );

   gf180mcu_fd_sc_mcu7t5v0__subs_serial #(.WIDTH(2)) dut2 (
      .CLK(CLK), .RN(RN), .A(A2), .B(B2), .BI(BI2), .IN_VALID(IN_VALID2), .IN_READY(IN_READY2),
      .D(D2), .BO(BO2), .OUT_VALID(OUT_VALID2), .OUT_READY(OUT_READY2), .BUSY(BUSY2)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Present operands on the 8-bit instance and complete the handshake.
   task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic bi);
      int guard = 0;
      while (!IN_READY && guard < 50) begin
         tick();
         guard++;
      end
      check_eq("in_ready_before_start", IN_READY, 1);
      A = a; B = b; BI = bi; IN_VALID = 1'b1;
      tick();
      IN_VALID = 1'b0; A = '0; B = '0; BI = 1'b0;
   endtask

   // Count edges from the accepting edge to OUT_VALID, and BUSY cycles meanwhile.
   task automatic wait_done8(output int lat, output int busy_cyc);
      lat = 0;
      busy_cyc = 0;
      while (!OUT_VALID && lat < 40) begin
         if (BUSY) busy_cyc++;
         tick();
         lat++;
      end
   endtask

   task automatic release8();
      OUT_READY = 1'b1;
      tick();
      OUT_READY = 1'b0;
      check_eq("out_valid_after_release", OUT_VALID, 0);
   endtask

   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic bi, input logic [7:0] exp_d, input logic exp_bo);
      int lat, bc;
      start8(a, b, bi);
      wait_done8(lat, bc);
      check_eq({tag, "_lat"}, lat, 8);
      check_eq({tag, "_d"}, D, exp_d);
      check_eq({tag, "_bo"}, BO, exp_bo);
      release8();
   endtask

   initial begin
      int lat, bc;
      logic [7:0] d_hold;
      logic       bo_hold;
      logic       saw_valid;
      logic [8:0] ref9;
      logic [2:0] ref3;
      logic [7:0] ra, rb;
      logic       rbi;
      logic [1:0] qa, qb;
      logic       qbi;
      int         guard;

      // 1. Reset with IN_VALID asserted
      IN_VALID = 1'b1; A = 8'hAA; B = 8'h11; BI = 1'b1;
      repeat (3) tick();
      check_eq("rst_out_valid", OUT_VALID, 0);
      check_eq("rst_d", D, 8'h00);
      check_eq("rst_bo", BO, 0);
      check_eq("rst_busy", BUSY, 0);
      check_eq("rst_in_ready", IN_READY, 1);
      IN_VALID = 1'b0;
      RN = 1'b1;
      tick();

      // 2. Basic subtraction, latency and BUSY length
      start8(8'h5A, 8'h23, 1'b0);
      check_eq("basic_busy_after_accept", BUSY, 1);
      wait_done8(lat, bc);
      check_eq("basic_latency", lat, 8);
      check_eq("basic_busy_cycles", bc, 8);
      check_eq("basic_d", D, 8'h37);
      check_eq("basic_bo", BO, 0);
      release8();

      // 3. Borrow cases
      op8("borrow_0m1", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
      op8("borrow_bi", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);
      op8("noborrow_ff", 8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0);

      // 4. Backpressure in DONE, IN_VALID ignored
      start8(8'h33, 8'h11, 1'b0);
      wait_done8(lat, bc);
      d_hold = D; bo_hold = BO;
      check_eq("bp_d_start", d_hold, 8'h22);
      for (int i = 0; i < 5; i++) begin
         A = 8'hAA; B = 8'h01; BI = 1'b1; IN_VALID = (i % 2 == 0);
         check_eq("bp_in_ready", IN_READY, 0);
         tick();
         check_eq("bp_out_valid", OUT_VALID, 1);
         check_eq("bp_d_stable", D, d_hold);
         check_eq("bp_bo_stable", BO, bo_hold);
         check_eq("bp_busy", BUSY, 0);
      end
      IN_VALID = 1'b0;
      release8();
      check_eq("bp_idle_ready", IN_READY, 1);

      // 5. Back-to-back consume + accept
      start8(8'h40, 8'h01, 1'b0);
      wait_done8(lat, bc);
      check_eq("b2b_first_d", D, 8'h3F);
      OUT_READY = 1'b1; IN_VALID = 1'b1; A = 8'h80; B = 8'h01; BI = 1'b0;
      #1;
      check_eq("b2b_in_ready", IN_READY, 1);
      tick();
      OUT_READY = 1'b0; IN_VALID = 1'b0;
      check_eq("b2b_busy", BUSY, 1);
      check_eq("b2b_out_valid_low", OUT_VALID, 0);
      wait_done8(lat, bc);
      check_eq("b2b_latency", lat, 8);
      check_eq("b2b_d", D, 8'h7F);
      check_eq("b2b_bo", BO, 0);
      release8();

      // 6. Reset in RUN cycle 3
      start8(8'h0F, 8'hF0, 1'b1);
      repeat (3) tick();
      check_eq("midrst_busy_before", BUSY, 1);
      RN = 1'b0;
      #1;
      check_eq("midrst_out_valid", OUT_VALID, 0);
      check_eq("midrst_d", D, 8'h00);
      check_eq("midrst_bo", BO, 0);
      check_eq("midrst_busy", BUSY, 0);
      check_eq("midrst_in_ready", IN_READY, 1);
      tick();
      RN = 1'b1;
      saw_valid = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (OUT_VALID) saw_valid = 1'b1;
      end
      check_eq("midrst_no_valid", saw_valid, 0);

      // Random, WIDTH=8
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
         ref9 = {1'b0, ra} - {1'b0, rb} - {8'h00, rbi};
         start8(ra, rb, rbi);
         wait_done8(lat, bc);
         check_eq("rand8", {BO, D}, ref9);
         OUT_READY = 1'b1;
         tick();
         OUT_READY = 1'b0;
      end

      // Random, WIDTH=2
      for (int i = 0; i < 1000; i++) begin
         qa = 2'($urandom); qb = 2'($urandom); qbi = 1'($urandom);
         ref3 = {1'b0, qa} - {1'b0, qb} - {2'b00, qbi};
         guard = 0;
         while (!IN_READY2 && guard < 20) begin
            tick();
            guard++;
         end
         A2 = qa; B2 = qb; BI2 = qbi; IN_VALID2 = 1'b1;
         tick();
         IN_VALID2 = 1'b0;
         lat = 0;
         while (!OUT_VALID2 && lat < 20) begin
            tick();
            lat++;
         end
         check_eq("rand2", {lat[7:0], BO2, D2}, {8'd2, ref3});
         OUT_READY2 = 1'b1;
         tick();
         OUT_READY2 = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
